// File: rtl/branch_queue_pkg.sv
// Shared types and constants for the branch-resolution queue.
// XLEN comes from the project-wide `XLEN define when present, else 32.
// The head fields of br_entry_t map 1:1 onto the PC unit's pc_in branch fields.
`ifndef XLEN
`define XLEN 32
`endif

package branch_queue_pkg;

    localparam int BRQ_DEPTH  = 8;       // default entry count, power of two
    localparam int BRQ_TID_W  = 3;       // 8 barrel threads
    localparam int BRQ_XLEN   = `XLEN;   // address width
    localparam int BRQ_PERF_W = 32;      // performance counter width

    // One queue slot.
    typedef struct packed {
        logic                 alloc;
        logic                 resolved;
        logic                 taken;
        logic [BRQ_TID_W-1:0] thread_id;
        logic [BRQ_XLEN-1:0]  target;
    } br_entry_t;

    // Decode-side allocation request.
    typedef struct packed {
        logic                 valid;
        logic [BRQ_TID_W-1:0] thread_id;
    } brq_alloc_t;

    // Execute-side resolution request (the tag travels alongside).
    typedef struct packed {
        logic                valid;
        logic                taken;
        logic [BRQ_XLEN-1:0] target;
    } brq_res_t;

    // A not-taken branch has no meaningful target; store zero so the
    // head never shows a stale address.
    function automatic logic [BRQ_XLEN-1:0] masked_target(
        input logic                taken,
        input logic [BRQ_XLEN-1:0] target
    );
        return taken ? target : '0;
    endfunction

endpackage

// File: rtl/brq_perf_cnt.sv
// Saturating 32-bit event counter with an increment enable.
// Used twice by branch_queue when BRQ_PERF_EN is defined.
module brq_perf_cnt
    import branch_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    output logic [BRQ_PERF_W-1:0] count_o
);

    // Count enabled events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + BRQ_PERF_W'(1);
        end
    end

endmodule

// File: rtl/branch_queue.sv
// In-order branch-resolution FIFO feeding the fetch PC unit.
// Decode allocates an entry per issued branch, execute resolves it by tag,
// and the head is presented to the PC unit. Taken heads retire on br_ack_i;
// not-taken heads retire once the PC unit services that thread unstalled.
// Optional feature macro: BRQ_PERF_EN adds saturating taken/not-taken pop counters.
module branch_queue
    import branch_queue_pkg::*;
#(
    parameter  int DEPTH = BRQ_DEPTH,
    localparam int TID_W = BRQ_TID_W,
    localparam int XLEN  = BRQ_XLEN,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid_i,
    input  logic [TID_W-1:0] alloc_thread_id_i,
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             res_valid_i,
    input  logic [TAG_W-1:0] res_tag_i,
    input  logic             res_taken_i,
    input  logic [XLEN-1:0]  res_target_i,
    input  logic [TID_W-1:0] pc_thread_id_i,
    input  logic             pc_stall_i,
    input  logic             br_ack_i,
    output logic             branch_fifo_empty_o,
    output logic [TID_W-1:0] br_thread_id_o,
    output logic             br_valid_o,
    output logic             br_true_o,
    output logic [XLEN-1:0]  br_pc_o
`ifdef BRQ_PERF_EN
    ,
    output logic [BRQ_PERF_W-1:0] perf_taken_o,
    output logic [BRQ_PERF_W-1:0] perf_not_taken_o
`endif
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_W = TAG_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [TAG_W-1:0] rd_idx;
    logic [TAG_W-1:0] wr_idx;

    // Control bits (reset) and payload (not reset), per entry.
    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] resolved_q;
    logic [DEPTH-1:0] taken_q;
    logic [TID_W-1:0] tid_q    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];

    brq_alloc_t alloc_req;
    brq_res_t   res_req;
    br_entry_t  head;

    logic empty;
    logic full;
    logic head_live;
    logic head_ready;
    logic alloc_fire;
    logic res_fire;
    logic pop;

    assign rd_idx = rd_ptr[TAG_W-1:0];
    assign wr_idx = wr_ptr[TAG_W-1:0];

    assign alloc_req = '{valid: alloc_valid_i, thread_id: alloc_thread_id_i};
    assign res_req   = '{valid: res_valid_i, taken: res_taken_i, target: res_target_i};

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[TAG_W] != wr_ptr[TAG_W]) && (rd_idx == wr_idx);

    // Gather the head slot into one struct view.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        head           = '0;
        head.alloc     = alloc_q[rd_idx];
        head.resolved  = resolved_q[rd_idx];
        head.taken     = taken_q[rd_idx];
        head.thread_id = tid_q[rd_idx];
        head.target    = target_q[rd_idx];
    end

    assign head_live  = !empty && head.alloc;
    assign head_ready = head_live && head.resolved;

    // Readiness is a function of occupancy only, so a full queue refuses an
    // alloc even when the head pops in the same cycle.
    assign alloc_fire = alloc_req.valid && !full;

    // Only an allocated, still-unresolved entry accepts a resolve; this makes
    // the first resolve win and drops resolves for free (including
    // not-yet-issued) tags.
    assign res_fire = res_req.valid && alloc_q[res_tag_i] && !resolved_q[res_tag_i];

    // Uses the registered resolved bit, so a head resolved this cycle pops no earlier than next cycle.
    assign pop = head_ready &&
                 (head.taken ? br_ack_i
                             : (!pc_stall_i && (pc_thread_id_i == head.thread_id)));

    // Pointer and per-entry control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            alloc_q    <= '0;
            resolved_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
            if (alloc_fire) begin
                wr_ptr             <= wr_ptr + PTR_W'(1);
                alloc_q[wr_idx]    <= 1'b1;
                resolved_q[wr_idx] <= 1'b0;
            end
            if (res_fire) begin
                resolved_q[res_tag_i] <= 1'b1;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + PTR_W'(1);
                alloc_q[rd_idx]    <= 1'b0;
                resolved_q[rd_idx] <= 1'b0;
            end
        end
    end

    // Entry payload, written on alloc (thread) and on resolve (outcome).
    // NOTE: the payload array has no reset; it is never observed until the alloc/resolved bits qualify it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            tid_q[wr_idx] <= alloc_req.thread_id;
        end
        if (res_fire) begin
            taken_q[res_tag_i]  <= res_req.taken;
            target_q[res_tag_i] <= masked_target(res_req.taken, res_req.target);
        end
    end

    assign alloc_ready_o       = !full;
    assign alloc_tag_o         = wr_idx;
    assign branch_fifo_empty_o = empty;

    // Head view is forced to zero when no entry is live; outcome fields are
    // also held at zero until the head is resolved.
    assign br_thread_id_o = head_live  ? head.thread_id : '0;
    assign br_valid_o     = head_ready;
    assign br_true_o      = head_ready && head.taken;
    assign br_pc_o        = head_ready ? head.target : '0;

`ifdef BRQ_PERF_EN
    brq_perf_cnt u_perf_taken (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (pop && head.taken),
        .count_o (perf_taken_o)
    );

    brq_perf_cnt u_perf_not_taken (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (pop && !head.taken),
        .count_o (perf_not_taken_o)
    );
`endif

endmodule

// File: tb/tb_branch_queue.sv
// Directed testbench for branch_queue: a table of single-cycle vectors for
// the taken / not-taken / illegal-event flows, then hand-written sequences
// for mid-stream reset, fill, out-of-order resolve, full-with-pop and wrap.
// Define BRQ_PERF_EN to also check the pop counters.
module tb_branch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid_i;
    logic [2:0]  alloc_thread_id_i;
    logic        alloc_ready_o;
    logic [2:0]  alloc_tag_o;
    logic        res_valid_i;
    logic [2:0]  res_tag_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic [2:0]  pc_thread_id_i;
    logic        pc_stall_i;
    logic        br_ack_i;
    logic        branch_fifo_empty_o;
    logic [2:0]  br_thread_id_o;
    logic        br_valid_o;
    logic        br_true_o;
    logic [31:0] br_pc_o;
`ifdef BRQ_PERF_EN
    logic [31:0] perf_taken_o;
    logic [31:0] perf_not_taken_o;
`endif

    int checks = 0;
    int errors = 0;

    branch_queue dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_valid_i       (alloc_valid_i),
        .alloc_thread_id_i   (alloc_thread_id_i),
        .alloc_ready_o       (alloc_ready_o),
        .alloc_tag_o         (alloc_tag_o),
        .res_valid_i         (res_valid_i),
        .res_tag_i           (res_tag_i),
        .res_taken_i         (res_taken_i),
        .res_target_i        (res_target_i),
        .pc_thread_id_i      (pc_thread_id_i),
        .pc_stall_i          (pc_stall_i),
        .br_ack_i            (br_ack_i),
        .branch_fifo_empty_o (branch_fifo_empty_o),
        .br_thread_id_o      (br_thread_id_o),
        .br_valid_o          (br_valid_o),
        .br_true_o           (br_true_o),
        .br_pc_o             (br_pc_o)
`ifdef BRQ_PERF_EN
        ,
        .perf_taken_o        (perf_taken_o),
        .perf_not_taken_o    (perf_not_taken_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        av;
        logic [2:0]  atid;
        logic        rv;
        logic [2:0]  rtag;
        logic        rtk;
        logic [31:0] rtgt;
        logic [2:0]  ptid;
        logic        pstall;
        logic        ack;
        logic        e_empty;
        logic        e_ready;
        logic [2:0]  e_tag;
        logic [2:0]  e_tid;
        logic        e_valid;
        logic        e_true;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input string n,
        input logic av, input logic [2:0] atid,
        input logic rv, input logic [2:0] rtag, input logic rtk, input logic [31:0] rtgt,
        input logic [2:0] ptid, input logic pstall, input logic ack,
        input logic e_empty, input logic e_ready, input logic [2:0] e_tag,
        input logic [2:0] e_tid, input logic e_valid, input logic e_true, input logic [31:0] e_pc
    );
        vec_t v;
        v.name = n;     v.av = av;         v.atid = atid;
        v.rv = rv;      v.rtag = rtag;     v.rtk = rtk;       v.rtgt = rtgt;
        v.ptid = ptid;  v.pstall = pstall; v.ack = ack;
        v.e_empty = e_empty; v.e_ready = e_ready; v.e_tag = e_tag;
        v.e_tid = e_tid;     v.e_valid = e_valid; v.e_true = e_true; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string n, input logic e_empty, input logic e_ready,
                             input logic [2:0] e_tag, input logic [2:0] e_tid,
                             input logic e_valid, input logic e_true, input logic [31:0] e_pc);
        check({n, ".empty"}, 32'(branch_fifo_empty_o), 32'(e_empty));
        check({n, ".ready"}, 32'(alloc_ready_o),       32'(e_ready));
        check({n, ".tag"},   32'(alloc_tag_o),         32'(e_tag));
        check({n, ".tid"},   32'(br_thread_id_o),      32'(e_tid));
        check({n, ".valid"}, 32'(br_valid_o),          32'(e_valid));
        check({n, ".true"},  32'(br_true_o),           32'(e_true));
        check({n, ".pc"},    br_pc_o,                  e_pc);
    endtask

    task automatic set_idle();
        alloc_valid_i     = 1'b0;
        alloc_thread_id_i = '0;
        res_valid_i       = 1'b0;
        res_tag_i         = '0;
        res_taken_i       = 1'b0;
        res_target_i      = '0;
        pc_thread_id_i    = '0;
        pc_stall_i        = 1'b1;
        br_ack_i          = 1'b0;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            name               av atid rv tag tk tgt         ptid st ack | emp rdy tag tid v  t  pc
        vecs[0]  = mk("alloc_t3",         1, 3,  0, 0, 0, 32'h0,      0,  1, 0,   0,  1,  1,  3,  0, 0, 32'h0);
        vecs[1]  = mk("res_t0_taken",     0, 0,  1, 0, 1, 32'h100,    0,  1, 0,   0,  1,  1,  3,  1, 1, 32'h100);
        vecs[2]  = mk("ack_t0",           0, 0,  0, 0, 0, 32'h0,      0,  1, 1,   1,  1,  1,  0,  0, 0, 32'h0);
        vecs[3]  = mk("alloc_t5",         1, 5,  0, 0, 0, 32'h0,      0,  1, 0,   0,  1,  2,  5,  0, 0, 32'h0);
        vecs[4]  = mk("res_nt_pc_match",  0, 0,  1, 1, 0, 32'h55,     5,  0, 0,   0,  1,  2,  5,  1, 0, 32'h0);
        vecs[5]  = mk("pc_other_tid",     0, 0,  0, 0, 0, 32'h0,      2,  0, 0,   0,  1,  2,  5,  1, 0, 32'h0);
        vecs[6]  = mk("pc_stalled",       0, 0,  0, 0, 0, 32'h0,      5,  1, 0,   0,  1,  2,  5,  1, 0, 32'h0);
        vecs[7]  = mk("nt_retire",        0, 0,  0, 0, 0, 32'h0,      5,  0, 0,   1,  1,  2,  0,  0, 0, 32'h0);
        vecs[8]  = mk("ack_empty",        0, 0,  0, 0, 0, 32'h0,      0,  1, 1,   1,  1,  2,  0,  0, 0, 32'h0);
        vecs[9]  = mk("alloc_t1",         1, 1,  0, 0, 0, 32'h0,      0,  1, 0,   0,  1,  3,  1,  0, 0, 32'h0);
        vecs[10] = mk("ack_unresolved",   0, 0,  0, 0, 0, 32'h0,      1,  0, 1,   0,  1,  3,  1,  0, 0, 32'h0);
        vecs[11] = mk("res_t2_with_ack",  0, 0,  1, 2, 1, 32'h40,     0,  1, 1,   0,  1,  3,  1,  1, 1, 32'h40);
        vecs[12] = mk("res_t2_again",     0, 0,  1, 2, 0, 32'h99,     0,  1, 0,   0,  1,  3,  1,  1, 1, 32'h40);
        vecs[13] = mk("res_free_tag",     0, 0,  1, 5, 1, 32'h77,     1,  0, 0,   0,  1,  3,  1,  1, 1, 32'h40);
        vecs[14] = mk("ack_t2",           0, 0,  0, 0, 0, 32'h0,      0,  1, 1,   1,  1,  3,  0,  0, 0, 32'h0);
        vecs[15] = mk("alloc_res_same",   1, 4,  1, 3, 1, 32'h999,    0,  1, 0,   0,  1,  4,  4,  0, 0, 32'h0);
        vecs[16] = mk("res_t3_nt",        0, 0,  1, 3, 0, 32'h12,     0,  1, 0,   0,  1,  4,  4,  1, 0, 32'h0);
        vecs[17] = mk("alloc_and_pop",    1, 6,  0, 0, 0, 32'h0,      4,  0, 0,   0,  1,  5,  6,  0, 0, 32'h0);
        vecs[18] = mk("res_t4_alloc_t7",  1, 7,  1, 4, 1, 32'h200,    0,  1, 0,   0,  1,  6,  6,  1, 1, 32'h200);
        vecs[19] = mk("ack_t4",           0, 0,  0, 0, 0, 32'h0,      0,  1, 1,   0,  1,  6,  7,  0, 0, 32'h0);
        vecs[20] = mk("res_t5_taken",     0, 0,  1, 5, 1, 32'h300,    0,  1, 0,   0,  1,  6,  7,  1, 1, 32'h300);
        vecs[21] = mk("ack_t5",           0, 0,  0, 0, 0, 32'h0,      0,  1, 1,   1,  1,  6,  0,  0, 0, 32'h0);

        // Reset state, checked while reset is held.
        set_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1, 1, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;

        // Idle for 10 cycles: nothing may change.
        for (int i = 0; i < 10; i++) begin
            step();
            check_all($sformatf("idle%0d", i), 1, 1, 0, 0, 0, 0, 32'h0);
        end

        // Table-driven single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            alloc_valid_i     = vecs[i].av;
            alloc_thread_id_i = vecs[i].atid;
            res_valid_i       = vecs[i].rv;
            res_tag_i         = vecs[i].rtag;
            res_taken_i       = vecs[i].rtk;
            res_target_i      = vecs[i].rtgt;
            pc_thread_id_i    = vecs[i].ptid;
            pc_stall_i        = vecs[i].pstall;
            br_ack_i          = vecs[i].ack;
            step();
            check_all(vecs[i].name, vecs[i].e_empty, vecs[i].e_ready, vecs[i].e_tag,
                      vecs[i].e_tid, vecs[i].e_valid, vecs[i].e_true, vecs[i].e_pc);
        end
        set_idle();
`ifdef BRQ_PERF_EN
        check("perf_taken_table", perf_taken_o, 32'd4);
        check("perf_nt_table", perf_not_taken_o, 32'd2);
`endif

        // Mid-stream reset with 4 entries (tags 6,7,0,1).
        for (int i = 0; i < 4; i++) begin
            alloc_valid_i     = 1'b1;
            alloc_thread_id_i = 3'(i);
            step();
            check($sformatf("pre_rst_tag%0d", i), 32'(alloc_tag_o), 32'((6 + i + 1) % 8));
        end
        set_idle();
        check("pre_rst_empty", 32'(branch_fifo_empty_o), 32'd0);
        check("pre_rst_tid", 32'(br_thread_id_o), 32'd0);
        rst = 1'b0;
        #1;
        check_all("async_rst", 1, 1, 0, 0, 0, 0, 32'h0);
        step();
        check_all("rst_held", 1, 1, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;
`ifdef BRQ_PERF_EN
        check("perf_taken_rst", perf_taken_o, 32'd0);
        check("perf_nt_rst", perf_not_taken_o, 32'd0);
`endif
        // A resolve for a pre-reset tag must be ignored.
        res_valid_i  = 1'b1;
        res_tag_i    = 3'd6;
        res_taken_i  = 1'b1;
        res_target_i = 32'h666;
        step();
        set_idle();
        check_all("stale_res", 1, 1, 0, 0, 0, 0, 32'h0);

        // Fill all 8 entries; tag tracks the tail.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_tag%0d", i), 32'(alloc_tag_o), 32'(i));
            alloc_valid_i     = 1'b1;
            alloc_thread_id_i = 3'(i);
            step();
        end
        check_all("full", 0, 0, 0, 0, 0, 0, 32'h0);
        // 9th alloc is dropped.
        alloc_thread_id_i = 3'd7;
        step();
        set_idle();
        check_all("full_drop", 0, 0, 0, 0, 0, 0, 32'h0);

        // Resolve out of order, 7 down to 0; even tags taken.
        for (int t = 7; t >= 0; t--) begin
            res_valid_i  = 1'b1;
            res_tag_i    = 3'(t);
            res_taken_i  = (t % 2) == 0;
            res_target_i = 32'h1000 + 32'(t * 16);
            step();
            if (t != 0) check($sformatf("ooo_head_unres%0d", t), 32'(br_valid_o), 32'd0);
        end
        set_idle();
        check_all("head0_res", 0, 0, 0, 0, 1, 1, 32'h1000);

        // Pop while full plus an alloc: alloc refused, occupancy drops to 7.
        alloc_valid_i     = 1'b1;
        alloc_thread_id_i = 3'd5;
        br_ack_i          = 1'b1;
        step();
        set_idle();
        check_all("full_pop", 0, 1, 0, 1, 1, 0, 32'h0);

        // Drain remaining heads in alloc order.
        for (int i = 1; i < 8; i++) begin
            check($sformatf("drain%0d.tid", i), 32'(br_thread_id_o), 32'(i));
            check($sformatf("drain%0d.valid", i), 32'(br_valid_o), 32'd1);
            check($sformatf("drain%0d.true", i), 32'(br_true_o), 32'((i % 2) == 0));
            check($sformatf("drain%0d.pc", i), br_pc_o,
                  ((i % 2) == 0) ? 32'h1000 + 32'(i * 16) : 32'h0);
            if ((i % 2) == 0) begin
                br_ack_i = 1'b1;
            end else begin
                pc_thread_id_i = 3'(i);
                pc_stall_i     = 1'b0;
            end
            step();
            set_idle();
        end
        check_all("drained", 1, 1, 0, 0, 0, 0, 32'h0);

        // Wrap: next alloc lands on tag 0.
        alloc_valid_i     = 1'b1;
        alloc_thread_id_i = 3'd6;
        step();
        set_idle();
        check_all("wrap_alloc", 0, 1, 1, 6, 0, 0, 32'h0);

`ifdef BRQ_PERF_EN
        check("perf_taken_end", perf_taken_o, 32'd4);
        check("perf_nt_end", perf_not_taken_o, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
